reset_request_generator: RTL and testbench



---
 rtl/reset_pkg.sv | 28 ++
 rtl/button_debouncer.sv | 59 +++++
 rtl/reset_request_generator.sv | 106 ++++++++++
 tb/tb_reset_request_generator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
// Shared definitions for the reset request path: FSM states, cause encoding
// and the fixed-priority cause selector.
package reset_pkg;

  localparam int CAUSE_W      = 3;
  localparam int CAUSE_BUTTON = 0;
  localparam int CAUSE_WDT    = 1;
  localparam int CAUSE_SW     = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } rst_state_e;

  typedef logic [CAUSE_W-1:0] cause_t;

  // Button beats watchdog beats software; result is one-hot or zero.
  function automatic cause_t select_cause(input logic btn, input logic wdt, input logic sw);
    cause_t c;
    c = '0;
    if (btn)      c[CAUSE_BUTTON] = 1'b1;
    else if (wdt) c[CAUSE_WDT]    = 1'b1;
    else if (sw)  c[CAUSE_SW]     = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and registered rising-edge strobe
// for the raw reset button.
module button_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic I_CLK,
  input  logic I_ASYNC_RESET,
  input  logic button,
  output logic rise
);

  logic        sync_p0;
  logic        sync_p1;
  logic        level_p2;
  logic        level_p3;
  logic [15:0] stable_cnt;

  // Stage 0/1: metastability synchronizer
  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: level follows the input only after an unbroken run of mismatches
  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      level_p2   <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_p1 == level_p2) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DEBOUNCE_CYCLES - 16'd1) begin
      level_p2   <= sync_p1;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 16'd1;
    end
  end

  // Stage 3: rising-edge detect
  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      level_p3 <= 1'b0;
      rise     <= 1'b0;
    end else begin
      level_p3 <= level_p2;
      rise     <= level_p2 & ~level_p3;
    end
  end

  a_deb_nonzero: assert property (@(posedge I_CLK) disable iff (I_ASYNC_RESET)
                                  DEBOUNCE_CYCLES != 16'd0)
    else $error("button_debouncer: DEBOUNCE_CYCLES must be nonzero");

endmodule

// File: rtl/reset_request_generator.sv
// Merges button, watchdog and software triggers into one fixed-width reset
// pulse with holdoff, and keeps a sticky record of the last cause.
module reset_request_generator
  import reset_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES  = 16'd50000,
  parameter logic [23:0] WDT_CYCLES       = 24'd4000000,
  parameter logic [7:0]  REQ_PULSE_CYCLES = 8'd8,
  parameter logic [7:0]  HOLDOFF_CYCLES   = 8'd64
) (
  input  logic               I_CLK,
  input  logic               I_ASYNC_RESET,
  input  logic               I_BUTTON,
  input  logic               I_WDT_ENABLE,
  input  logic               I_WDT_KICK,
  input  logic               I_SW_RESET_REQ,
  output logic               O_SW_RESET_ACK,
  output logic               O_RESET_REQ,
  output logic [CAUSE_W-1:0] O_RESET_CAUSE,
  output logic               O_BUSY
);

  rst_state_e  state;
  rst_state_e  next_state;
  logic [7:0]  phase_cnt;
  logic [23:0] wdt_cnt;
  logic        btn_rise;
  logic        is_idle;
  logic        btn_trig;
  logic        wdt_trig;
  logic        sw_trig;
  cause_t      cause_sel;
  cause_t      cause_d;
  logic        req_d;
  logic        busy_d;
  logic        ack_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_button_debouncer (
    .I_CLK         (I_CLK),
    .I_ASYNC_RESET (I_ASYNC_RESET),
    .button        (I_BUTTON),
    .rise          (btn_rise)
  );

  assign is_idle   = (state == IDLE);
  assign btn_trig  = is_idle & btn_rise;
  assign wdt_trig  = is_idle & I_WDT_ENABLE & ~I_WDT_KICK & (wdt_cnt == '0);
  assign sw_trig   = is_idle & I_SW_RESET_REQ;
  assign cause_sel = select_cause(btn_trig, wdt_trig, sw_trig);

  // Watchdog only runs while idle and enabled; reaching zero reloads it too.
  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      wdt_cnt <= WDT_CYCLES - 24'd1;
    end else if (!is_idle || !I_WDT_ENABLE || I_WDT_KICK || (wdt_cnt == '0)) begin
      wdt_cnt <= WDT_CYCLES - 24'd1;
    end else begin
      wdt_cnt <= wdt_cnt - 24'd1;
    end
  end

  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      state          <= IDLE;
      phase_cnt      <= '0;
      O_RESET_REQ    <= 1'b0;
      O_BUSY         <= 1'b0;
      O_SW_RESET_ACK <= 1'b0;
      O_RESET_CAUSE  <= '0;
    end else begin
      state          <= next_state;
      phase_cnt      <= ((next_state != state) || is_idle) ? 8'd0 : phase_cnt + 8'd1;
      O_RESET_REQ    <= req_d;
      O_BUSY         <= busy_d;
      O_SW_RESET_ACK <= ack_d;
      O_RESET_CAUSE  <= cause_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (cause_sel != '0) next_state = ASSERT;
      ASSERT:  if (phase_cnt == REQ_PULSE_CYCLES - 8'd1) next_state = HOLDOFF;
      HOLDOFF: if (phase_cnt == HOLDOFF_CYCLES - 8'd1) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    req_d   = (next_state == ASSERT);
    busy_d  = (next_state != IDLE);
    ack_d   = cause_sel[CAUSE_SW];
    cause_d = O_RESET_CAUSE;
    if (cause_sel != '0) cause_d = cause_sel;
  end

  a_params_nonzero: assert property (@(posedge I_CLK) disable iff (I_ASYNC_RESET)
                                     (REQ_PULSE_CYCLES != 8'd0) && (HOLDOFF_CYCLES != 8'd0) &&
                                     (WDT_CYCLES != 24'd0))
    else $error("reset_request_generator: zero-valued timing parameter");

endmodule

// File: tb/tb_reset_request_generator.sv
// Directed bench for reset_request_generator with a cycle-level behavioural model.
module tb_reset_request_generator;

  localparam logic [15:0] DEB = 16'd4;
  localparam logic [23:0] WDT = 24'd20;
  localparam logic [7:0]  RP  = 8'd3;
  localparam logic [7:0]  HO  = 8'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       wdt_en;
  logic       kick;
  logic       sw_req;
  logic       ack;
  logic       req;
  logic       busy;
  logic [2:0] cause;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  logic req_prev  = 1'b0;

  always #5 clk = ~clk;

  reset_request_generator #(
    .DEBOUNCE_CYCLES  (DEB),
    .WDT_CYCLES       (WDT),
    .REQ_PULSE_CYCLES (RP),
    .HOLDOFF_CYCLES   (HO)
  ) dut (
    .I_CLK          (clk),
    .I_ASYNC_RESET  (rst),
    .I_BUTTON       (button),
    .I_WDT_ENABLE   (wdt_en),
    .I_WDT_KICK     (kick),
    .I_SW_RESET_REQ (sw_req),
    .O_SW_RESET_ACK (ack),
    .O_RESET_REQ    (req),
    .O_RESET_CAUSE  (cause),
    .O_BUSY         (busy)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: m_phase counts cycles since a request was accepted
  // (0 = idle); the button path is tracked as a queue of raw samples.
  int     m_phase, m_wdt, m_run;
  bit     m_level, m_pend, m_rise, m_ack;
  bit     t_btn, t_wdt, t_sw, idle, s;
  logic [2:0] m_cause;
  bit     bq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bq.delete();
      m_phase = 0; m_wdt = int'(WDT) - 1; m_run = 0;
      m_level = 0; m_pend = 0; m_rise = 0; m_ack = 0; m_cause = 3'b000;
    end else begin
      idle  = (m_phase == 0);
      t_btn = idle && m_rise;
      t_wdt = idle && wdt_en && !kick && (m_wdt == 0);
      t_sw  = idle && sw_req;
      if (!idle || !wdt_en || kick || m_wdt == 0) m_wdt = int'(WDT) - 1;
      else m_wdt = m_wdt - 1;
      m_ack = 0;
      if (t_btn)      begin m_cause = 3'b001; m_phase = 1; end
      else if (t_wdt) begin m_cause = 3'b010; m_phase = 1; end
      else if (t_sw)  begin m_cause = 3'b100; m_phase = 1; m_ack = 1; end
      else if (m_phase != 0) m_phase = (m_phase == int'(RP) + int'(HO)) ? 0 : m_phase + 1;
      // synchronized value is the raw sample from two cycles back
      bq.push_back(button);
      if (bq.size() > 3) void'(bq.pop_front());
      s = (bq.size() == 3) ? bq[0] : 1'b0;
      m_rise = m_pend;
      m_pend = 0;
      if (s != m_level) begin
        m_run++;
        if (m_run == int'(DEB)) begin m_level = s; m_run = 0; m_pend = s; end
      end else begin
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("model_req",   {7'd0, req},   {7'd0, (m_phase >= 1 && m_phase <= int'(RP))});
      chk("model_busy",  {7'd0, busy},  {7'd0, (m_phase != 0)});
      chk("model_ack",   {7'd0, ack},   {7'd0, m_ack});
      chk("model_cause", {5'd0, cause}, {5'd0, m_cause});
      if (req && !req_prev) pulses++;
      req_prev = req;
    end else begin
      req_prev = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin tick(1); n++; end
    if (n >= 100) chk("idle_timeout", {7'd0, busy}, 8'd0);
  endtask

  int p0;
  int found;

  initial begin
    rst = 1'b1; button = 0; wdt_en = 0; kick = 0; sw_req = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick(1);
    chk("por_req", {7'd0, req}, 8'd0);
    chk("por_ack", {7'd0, ack}, 8'd0);
    chk("por_busy", {7'd0, busy}, 8'd0);
    chk("por_cause", {5'd0, cause}, 8'd0);

    // Software handshake, request held through the first pulse
    tick(2);
    p0 = pulses;
    sw_req = 1;
    tick(1);
    chk("sw_req_rise", {7'd0, req}, 8'd1);
    chk("sw_ack", {7'd0, ack}, 8'd1);
    chk("sw_cause", {5'd0, cause}, 8'h04);
    tick(1);
    chk("sw_ack_one_cycle", {7'd0, ack}, 8'd0);
    tick(2);
    chk("sw_req_width", {7'd0, req}, 8'd0);
    chk("sw_busy_holdoff", {7'd0, busy}, 8'd1);
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      tick(1);
      if (ack === 1'b1) found = 1;
    end
    chk("sw_retrigger_ack", found[7:0], 8'd1);
    sw_req = 0;
    tick(12);
    chk("sw_two_pulses", 8'(pulses - p0), 8'd2);

    // Watchdog expiry with no kicks
    wait_idle(); tick(2);
    wdt_en = 1;
    tick(19);
    chk("wdt_before", {7'd0, req}, 8'd0);
    tick(1);
    chk("wdt_req", {7'd0, req}, 8'd1);
    chk("wdt_cause", {5'd0, cause}, 8'h02);
    chk("wdt_no_ack", {7'd0, ack}, 8'd0);
    wdt_en = 0;

    // Regular kicks keep the watchdog quiet
    wait_idle(); tick(2);
    p0 = pulses;
    wdt_en = 1;
    for (int i = 0; i < 200; i++) begin
      kick = (i % 15 == 0);
      tick(1);
    end
    kick = 0; wdt_en = 0;
    tick(2);
    chk("wdt_kicked_no_pulse", 8'(pulses - p0), 8'd0);

    // Watchdog and software together; button edge lands in holdoff
    wait_idle(); tick(2);
    p0 = pulses;
    wdt_en = 1;
    tick(18);
    button = 1;
    tick(1);
    sw_req = 1;
    tick(1);
    chk("sim_cause", {5'd0, cause}, 8'h02);
    chk("sim_no_ack", {7'd0, ack}, 8'd0);
    chk("sim_req", {7'd0, req}, 8'd1);
    sw_req = 0; wdt_en = 0;
    tick(20);
    button = 0;
    tick(20);
    chk("sim_one_pulse", 8'(pulses - p0), 8'd1);
    chk("holdoff_btn_cause", {5'd0, cause}, 8'h02);

    // Bouncy button then a stable press
    wait_idle(); tick(2);
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      button = ((i / 2) % 2 == 0);
      tick(1);
    end
    tick(5);
    chk("btn_before", {7'd0, req}, 8'd0);
    tick(1);
    chk("btn_req", {7'd0, req}, 8'd1);
    chk("btn_cause", {5'd0, cause}, 8'h01);
    tick(2);
    chk("btn_req_last", {7'd0, req}, 8'd1);
    tick(1);
    chk("btn_req_fall", {7'd0, req}, 8'd0);
    tick(20);
    chk("btn_one_pulse", 8'(pulses - p0), 8'd1);
    button = 0;
    tick(20);

    // Power-on reset in the middle of a pulse
    wait_idle(); tick(2);
    sw_req = 1;
    tick(1);
    chk("por_mid_req_high", {7'd0, req}, 8'd1);
    sw_req = 0;
    #3 rst = 1'b1;
    #1;
    chk("por_mid_req_drop", {7'd0, req}, 8'd0);
    chk("por_mid_cause", {5'd0, cause}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);
    chk("por_after_busy", {7'd0, busy}, 8'd0);
    chk("por_after_cause", {5'd0, cause}, 8'd0);
    p0 = pulses;
    tick(20);
    chk("por_no_pulse", 8'(pulses - p0), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
